inv_key_expansion: RTL and testbench

Sequential AES-128 inverse key-schedule engine, the decryption-side counterpart of key_expansion. It takes the round key of a given round and walks the schedule backward one round per clock until it reaches a requested earlier round. The SIMD decrypt path uses it to recover round keys from the final (round-10) key without storing all eleven. Keys use the same vector-register format as key_expansion: element [0] is word w0 of the round key, in AES big-endian byte order.

---
 rtl/inv_key_expansion.sv | 156 +++++++++++++++
 tb/tb_inv_key_expansion.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv_key_expansion.sv
// AES-128 inverse key schedule: walks a round key backward
// one round per clock until the requested earlier round.
module inv_key_expansion #(
   parameter int regSize = 32,
   parameter int vecSize = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [vecSize-1:0][regSize-1:0]   key_in,
   input  logic [3:0]                        start_round,
   input  logic [3:0]                        target_round,
   output logic                              busy,
   output logic                              done,
   output logic                              err,
   output logic [vecSize-1:0][regSize-1:0]   key_out,
   output logic [3:0]                        round_out
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   state_t                          state_q, state_d;
   logic [vecSize-1:0][regSize-1:0] key_q, key_d;
   logic [3:0]                      round_q, round_d;
   logic [3:0]                      target_q, target_d;
   logic                            bad_q, bad_d;
   logic                            busy_q, busy_d;
   logic                            done_q, done_d;
   logic                            err_q, err_d;

   logic [regSize-1:0]              b3, rot, sub;
   logic [vecSize-1:0][regSize-1:0] prev_key;
   logic [3:0]                      round_dec;
   logic                            bad_req;

   // One backward step of the schedule, purely from the current key
   always_comb begin
      b3  = key_q[3] ^ key_q[2];
      rot = {b3[23:0], b3[31:24]};
      sub = {SBOX[rot[31:24]], SBOX[rot[23:16]],
             SBOX[rot[15:8]],  SBOX[rot[7:0]]};
      prev_key[3] = b3;
      prev_key[2] = key_q[2] ^ key_q[1];
      prev_key[1] = key_q[1] ^ key_q[0];
      prev_key[0] = key_q[0] ^ sub ^ {rcon(round_q), 24'h0};
      round_dec   = round_q - 4'd1;
      bad_req     = (start_round == 4'd0) || (start_round > 4'd10)
                    || (target_round >= start_round);
   end

   // Next-state and registered-output logic for the IDLE/RUN/FIN sequencer
   always_comb begin
      state_d  = state_q;
      key_d    = key_q;
      round_d  = round_q;
      target_d = target_q;
      bad_d    = bad_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               key_d    = key_in;
               round_d  = start_round;
               target_d = target_round;
               bad_d    = bad_req;
               busy_d   = !bad_req;
               state_d  = bad_req ? FIN : RUN;
            end
         end
         RUN: begin
            key_d   = prev_key;
            round_d = round_dec;
            if (round_dec == target_q) begin
               busy_d  = 1'b0;
               state_d = FIN;
            end
         end
         FIN: begin
            done_d  = 1'b1;
            err_d   = bad_q;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         key_q    <= '0;
         round_q  <= '0;
         target_q <= '0;
         bad_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         key_q    <= key_d;
         round_q  <= round_d;
         target_q <= target_d;
         bad_q    <= bad_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign key_out   = key_q;
   assign round_out = round_q;

endmodule

// File: tb/tb_inv_key_expansion.sv
// Directed bench for the AES-128 inverse key schedule engine.
// Known FIPS-197 and zero-key round keys are checked.
module tb_inv_key_expansion;

   typedef logic [3:0][31:0] key_t;

   logic       clk;
   logic       rst;
   logic       start;
   key_t       key_in;
   logic [3:0] start_round;
   logic [3:0] target_round;
   logic       busy;
   logic       done;
   logic       err;
   key_t       key_out;
   logic [3:0] round_out;

   int vectors;
   int miscompares;
   int cyc;
   int bcnt;
   logic seen_done;

   key_t fips_k0, fips_k1, fips_k10;
   key_t zero_k0, zero_k1, zero_k10;
   key_t bad_keys [3];
   logic [3:0] bad_sr [3];
   logic [3:0] bad_tr [3];

   inv_key_expansion #(.regSize(32), .vecSize(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .key_in       (key_in),
      .start_round  (start_round),
      .target_round (target_round),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .key_out      (key_out),
      .round_out    (round_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic key_t mk(input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
      key_t k;
      k[0] = w0;
      k[1] = w1;
      k[2] = w2;
      k[3] = w3;
      return k;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_job(input key_t k, input logic [3:0] sr,
                            input logic [3:0] tr);
      @(negedge clk);
      key_in       = k;
      start_round  = sr;
      target_round = tr;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start        = 1'b0;
      key_in       = '1;
      start_round  = 4'hf;
      target_round = 4'hf;
   endtask

   task automatic wait_done(output int c, output int b);
      c = 0;
      b = busy ? 1 : 0;
      while (c < 40) begin
         @(posedge clk);
         #1;
         c++;
         if (busy) b++;
         if (done) break;
      end
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      rst          = 1'b0;
      start        = 1'b0;
      key_in       = '0;
      start_round  = '0;
      target_round = '0;

      fips_k0  = mk(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
      fips_k1  = mk(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605);
      fips_k10 = mk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6);
      zero_k0  = '0;
      zero_k1  = mk(32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363);
      zero_k10 = mk(32'hb4ef5bcb, 32'h3e92e211, 32'h23e951cf, 32'h6f8f188e);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_key", key_out, 0);
      check("rst_round", round_out, 0);
      @(negedge clk);
      rst = 1'b1;

      // FIPS-197 full unwind 10 -> 0
      start_job(fips_k10, 4'd10, 4'd0);
      wait_done(cyc, bcnt);
      check("fips_lat", cyc, 11);
      check("fips_busy", bcnt, 10);
      check("fips_key", key_out, fips_k0);
      check("fips_round", round_out, 0);
      check("fips_err", err, 0);
      @(posedge clk);
      #1;
      check("fips_done_pulse", done, 0);
      check("fips_hold", key_out, fips_k0);

      // zero-key schedule 10 -> 1
      start_job(zero_k10, 4'd10, 4'd1);
      wait_done(cyc, bcnt);
      check("zero_lat", cyc, 10);
      check("zero_key", key_out, zero_k1);
      check("zero_round", round_out, 1);

      // zero-key schedule 1 -> 0
      start_job(zero_k1, 4'd1, 4'd0);
      wait_done(cyc, bcnt);
      check("zero1_lat", cyc, 2);
      check("zero1_key", key_out, zero_k0);

      // single FIPS step 1 -> 0
      start_job(fips_k1, 4'd1, 4'd0);
      wait_done(cyc, bcnt);
      check("step_lat", cyc, 2);
      check("step_busy", bcnt, 1);
      check("step_key", key_out, fips_k0);
      check("step_err", err, 0);

      // illegal requests
      bad_keys[0] = fips_k1;  bad_sr[0] = 4'd0;  bad_tr[0] = 4'd0;
      bad_keys[1] = zero_k10; bad_sr[1] = 4'd11; bad_tr[1] = 4'd2;
      bad_keys[2] = fips_k10; bad_sr[2] = 4'd3;  bad_tr[2] = 4'd3;
      for (int i = 0; i < 3; i++) begin
         start_job(bad_keys[i], bad_sr[i], bad_tr[i]);
         wait_done(cyc, bcnt);
         check($sformatf("bad%0d_lat", i), cyc, 1);
         check($sformatf("bad%0d_busy", i), bcnt, 0);
         check($sformatf("bad%0d_err", i), err, 1);
         check($sformatf("bad%0d_key", i), key_out, bad_keys[i]);
         check($sformatf("bad%0d_round", i), round_out, bad_sr[i]);
      end
      @(posedge clk);
      #1;
      check("bad_err_clear", err, 0);

      // start during RUN is ignored
      start_job(fips_k10, 4'd10, 4'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      key_in       = zero_k10;
      start_round  = 4'd10;
      target_round = 4'd1;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(cyc, bcnt);
      check("ign_done", done, 1);
      check("ign_key", key_out, fips_k0);
      check("ign_round", round_out, 0);

      // back-to-back: start the cycle after done
      @(posedge clk);
      start_job(fips_k1, 4'd1, 4'd0);
      wait_done(cyc, bcnt);
      check("b2b_lat", cyc, 2);
      check("b2b_key", key_out, fips_k0);

      // reset in the middle of a run
      start_job(fips_k10, 4'd10, 4'd0);
      repeat (5) @(posedge clk);
      #1;
      check("mid_round", round_out, 5);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("mid_busy", busy, 0);
      check("mid_done", done, 0);
      check("mid_key", key_out, 0);
      check("mid_round0", round_out, 0);
      @(negedge clk);
      rst = 1'b1;
      seen_done = 1'b0;
      repeat (15) begin
         @(posedge clk);
         #1;
         seen_done = seen_done | done;
      end
      check("mid_no_done", seen_done, 0);
      start_job(zero_k1, 4'd1, 4'd0);
      wait_done(cyc, bcnt);
      check("post_lat", cyc, 2);
      check("post_key", key_out, zero_k0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
